// File: rtl/async_fifo_rd_pack.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_pack
//
// Read-side consumer for the asynchronous FIFO. Lives entirely in the read
// clock domain. It drains the FIFO's show-ahead port one word per clock and
// packs PACK consecutive words into one wide word. The wide word is presented
// on a registered valid/ready stream. The first word popped lands in the
// least-significant slice of out_data.
//
// Parameters
//   DATESIZE  width of one FIFO word
//   PACK      FIFO words per output word (2..16)
//   CNTSIZE   width of the wrapping pop statistics counter
//
// Ports
//   rclk       in   read clock, rising-edge
//   r_rstn     in   asynchronous active-low reset
//   rdata      in   FIFO head word, valid whenever rempty = 0
//   rempty     in   FIFO empty flag, registered in the rclk domain
//   rinc       out  pop strobe; the head word is consumed on the edge it is high
//   flush      in   synchronous discard of the partially assembled word
//   out_data   out  packed output word
//   out_valid  out  out_data holds a complete word
//   out_ready  in   downstream accepts out_data
//   fill       out  words currently held in the partial buffer (0..PACK-1)
//   pop_cnt    out  words popped since reset, wraps
// -----------------------------------------------------------------------------
module async_fifo_rd_pack #(
    parameter int DATESIZE = 8,
    parameter int PACK     = 4,
    parameter int CNTSIZE  = 16
) (
    input  logic                       rclk,
    input  logic                       r_rstn,
    input  logic [DATESIZE-1:0]        rdata,
    input  logic                       rempty,
    output logic                       rinc,
    input  logic                       flush,
    output logic [DATESIZE*PACK-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(PACK):0]      fill,
    output logic [CNTSIZE-1:0]         pop_cnt
);

    localparam int              IDXW     = $clog2(PACK) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PACK - 1);

    logic [IDXW-1:0]                idx;
    // Slot 0 is the oldest word, so {rdata, part_buf} is already in output order.
    logic [PACK-2:0][DATESIZE-1:0]  part_buf;
    logic                           closing;

    // The next pop would complete a word.
    assign closing = (idx == LAST_IDX);

    // Pop whenever there is a word and somewhere to put it. The closing word
    // needs the output register free, or freed on this same edge. rempty is
    // registered inside the FIFO, so this path does not loop back through it.
    assign rinc = !rempty && !flush && (!closing || !out_valid || out_ready);

    assign fill = idx;

    // NOTE: all state uses non-blocking assignments, so every branch below sees
    // the pre-edge values of idx/out_valid, just as rinc did.
    always_ff @(posedge rclk or negedge r_rstn) begin
        if (!r_rstn) begin
            idx       <= '0;
            // NOTE: the partial buffer is only PACK-1 flops, not a RAM, so it is
            // cleared with everything else; stale words never leak out after reset.
            part_buf  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            pop_cnt   <= '0;
        end else begin
            if (rinc) begin
                pop_cnt <= pop_cnt + CNTSIZE'(1);
                if (closing) begin
                    idx <= '0;
                end else begin
                    for (int i = 0; i < PACK - 1; i++) begin
                        if (idx == IDXW'(i)) begin
                            part_buf[i] <= rdata;
                        end
                    end
                    idx <= idx + IDXW'(1);
                end
            end else if (flush) begin
                // Flush only rewinds assembly; a finished word still goes out.
                idx <= '0;
            end

            if (rinc && closing) begin
                // Any word accepted on this edge is replaced with no bubble.
                out_data  <= {rdata, part_buf};
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_pack.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_rd_pack
//
// Self-checking bench for async_fifo_rd_pack (PACK=4, DATESIZE=8, CNTSIZE=4).
// A queue stands in for the FIFO. A small reference model predicts rinc, fill,
// out_valid and pop_cnt each cycle. Completed words go onto a scoreboard when
// the model assembles them, and are popped and compared when the DUT hands a
// word over (out_valid & out_ready).
// -----------------------------------------------------------------------------
module tb_async_fifo_rd_pack;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = 4;

    logic              rclk = 1'b0;
    logic              r_rstn = 1'b0;
    logic [DW-1:0]     rdata = '0;
    logic              rempty = 1'b1;
    logic              rinc;
    logic              flush = 1'b0;
    logic [DW*PK-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2:0]        fill;
    logic [CW-1:0]     pop_cnt;

    async_fifo_rd_pack #(.DATESIZE(DW), .PACK(PK), .CNTSIZE(CW)) dut (
        .rclk      (rclk),
        .r_rstn    (r_rstn),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .pop_cnt   (pop_cnt)
    );

    always #5 rclk = ~rclk;

    // FIFO contents, scoreboard, and words the DUT actually delivered.
    logic [DW-1:0]    fifo_q[$];
    logic [DW*PK-1:0] exp_q[$];
    logic [DW*PK-1:0] got_q[$];

    // Reference model state.
    int            m_idx;
    logic [DW-1:0] m_buf[PK-1];
    bit            m_valid;
    logic [CW-1:0] m_cnt;
    bit            last_rinc;

    int n_pass  = 0;
    int n_total = 0;

    task automatic model_clear();
        m_idx   = 0;
        m_valid = 1'b0;
        m_cnt   = '0;
        for (int i = 0; i < PK - 1; i++) m_buf[i] = '0;
        fifo_q.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    // One clock cycle. Inputs are driven on the falling edge, outputs are
    // checked 1 ns later, and the task returns at the next falling edge.
    task automatic cycle(input bit rd, input bit fl, input bit starve);
        logic [DW*PK-1:0] w;
        bit er;
        bit last;
        out_ready = rd;
        flush     = fl;
        rempty    = starve || (fifo_q.size() == 0);
        rdata     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        last = (m_idx == PK - 1);
        er   = !rempty && !fl && (!last || !m_valid || rd);

        n_total++;
        if (rinc !== er) $display("FAIL rinc @%0t: got %b want %b", $time, rinc, er);
        else n_pass++;
        n_total++;
        if (fill !== 3'(m_idx)) $display("FAIL fill @%0t: got %0d want %0d", $time, fill, m_idx);
        else n_pass++;
        n_total++;
        if (out_valid !== m_valid) $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_valid);
        else n_pass++;
        n_total++;
        if (pop_cnt !== m_cnt) $display("FAIL pop_cnt @%0t: got %0d want %0d", $time, pop_cnt, m_cnt);
        else n_pass++;

        if (m_valid && rd) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard @%0t: handshake with no expected word", $time);
            end else begin
                w = exp_q.pop_front();
                if (out_data !== w) $display("FAIL out_data @%0t: got %h want %h", $time, out_data, w);
                else n_pass++;
            end
            got_q.push_back(out_data);
        end

        last_rinc = rinc;

        // Advance the model across the coming edge.
        if (er) begin
            m_cnt = m_cnt + CW'(1);
            if (!last) begin
                m_buf[m_idx] = rdata;
                m_idx++;
            end else begin
                w = {rdata, m_buf[2], m_buf[1], m_buf[0]};
                exp_q.push_back(w);
                m_idx = 0;
            end
        end else if (fl) begin
            m_idx = 0;
        end
        if (er && last) m_valid = 1'b1;
        else if (m_valid && rd) m_valid = 1'b0;

        if (rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge rclk);
    endtask

    task automatic do_reset();
        r_rstn    = 1'b0;
        rempty    = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        @(negedge rclk);
        r_rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge rclk);
        r_rstn = 1'b0;
        rempty = 1'b1;
        model_clear();
        #1;
        n_total++;
        if (out_valid !== 1'b0 || rinc !== 1'b0 || pop_cnt !== '0 || fill !== '0 || out_data !== '0)
            $display("FAIL reset_state: valid=%b rinc=%b cnt=%0d fill=%0d data=%h want all 0",
                     out_valid, rinc, pop_cnt, fill, out_data);
        else n_pass++;
        @(negedge rclk);
        r_rstn = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        n_total++;
        if (pop_cnt !== '0) $display("FAIL idle_no_pop: pop_cnt got %0d want 0", pop_cnt);
        else n_pass++;
    endtask

    task automatic test_streaming();
        int first_i = -1;
        int last_i  = -1;
        int n_rinc  = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (last_rinc) begin
                if (first_i < 0) first_i = i;
                last_i = i;
                n_rinc++;
            end
        end
        n_total++;
        if (n_rinc != 8 || last_i - first_i != 7)
            $display("FAIL stream_rinc_run: got %0d pops over span %0d want 8 over 7", n_rinc, last_i - first_i);
        else n_pass++;
        n_total++;
        if (got_q.size() != 2 || got_q[0] !== 32'h04030201 || got_q[1] !== 32'h08070605)
            $display("FAIL stream_words: got %0d words want 04030201,08070605", got_q.size());
        else n_pass++;
        n_total++;
        if (pop_cnt !== 4'd8) $display("FAIL stream_pop_cnt: got %0d want 8", pop_cnt);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + DW'(i));
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h13121110 || fill !== 3'd3 || last_rinc !== 1'b0)
            $display("FAIL bp_stall: valid=%b data=%h fill=%0d rinc=%b want 1 13121110 3 0",
                     out_valid, out_data, fill, last_rinc);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== 32'h13121110)
            $display("FAIL bp_accept: got %0d words want 13121110", got_q.size());
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h17161514 || fill !== 3'd0)
            $display("FAIL bp_reload: valid=%b data=%h fill=%0d want 1 17161514 0", out_valid, out_data, fill);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_starved();
        do_reset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA0 + DW'(i));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, (i % 2) == 0);
            n_total++;
            if (last_rinc && rempty) $display("FAIL starve_pop_empty: rinc=1 with rempty=1 in cycle %0d", i);
            else n_pass++;
        end
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== 32'hA3A2A1A0)
            $display("FAIL starve_word: got %0d words want A3A2A1A0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h66);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_total++;
        if (fill !== 3'd2) $display("FAIL flush_pre_fill: got %0d want 2", fill);
        else n_pass++;
        for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
        cycle(1'b1, 1'b1, 1'b0);
        n_total++;
        if (last_rinc !== 1'b0 || fill !== 3'd0 || fifo_q.size() != 4)
            $display("FAIL flush_cycle: rinc=%b fill=%0d fifo=%0d want 0 0 4", last_rinc, fill, fifo_q.size());
        else n_pass++;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== 32'h04030201)
            $display("FAIL flush_word: got %0d words want only 04030201", got_q.size());
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'hC0 + DW'(i));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
        n_total++;
        if (pop_cnt !== 4'd1 || fill !== 3'd1)
            $display("FAIL cnt_wrap: pop_cnt=%0d fill=%0d want 1 1", pop_cnt, fill);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        // Partial word (fill=1) and a nonzero counter are still present here.
        #2;
        r_rstn = 1'b0;
        #1;
        n_total++;
        if (fill !== '0 || pop_cnt !== '0 || out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL reset_mid: fill=%0d cnt=%0d valid=%b data=%h want all 0",
                     fill, pop_cnt, out_valid, out_data);
        else n_pass++;
        model_clear();
        @(negedge rclk);
        r_rstn = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_starved();
        test_flush();
        test_counter_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/async_fifo_rd_pack.md
# async_fifo_rd_pack

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It drains the FIFO's show-ahead read port (`rdata` / `rempty` / `rinc`) and packs `PACK` consecutive words into one wide word. The wide word is presented on a registered valid/ready output stream. It is the downstream end of the FIFO: the FIFO writer fills the queue, and this block empties it at up to one word per `rclk`.

## Interface

Parameters:
- `DATESIZE`, default 8: width of one FIFO word.
- `PACK`, default 4, legal 2..16: FIFO words per output word.
- `CNTSIZE`, default 16: width of the pop statistics counter.

Ports:
- `rclk`  in  1: read clock. One clock; all logic is on its rising edge.
- `r_rstn`  in  1: reset, asynchronous, active-low.
- `rdata`  in  DATESIZE: FIFO head word. Valid whenever `rempty`=0.
- `rempty`  in  1: FIFO empty flag, already synchronous to `rclk`.
- `rinc`  out  1: pop strobe to FIFO. The word is consumed at the rising edge where `rinc`=1.
- `flush`  in  1: synchronous; discards the partially assembled word.
- `out_data`  out  DATESIZE*PACK: packed word. The first-popped word sits in bits [DATESIZE-1:0].
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: downstream accepts `out_data`.
- `fill`  out  clog2(PACK)+1: number of words currently held in the partial buffer (0..PACK-1).
- `pop_cnt`  out  CNTSIZE: total words popped since reset, wraps.

## Operation

- Internal state:
  - partial buffer of PACK-1 words;
  - index `idx`, 0..PACK-1;
  - output register `out_data` / `out_valid`;
  - counter `pop_cnt`.
- Reset values: `idx`=0, `fill`=0, `out_valid`=0, `out_data`=0, `pop_cnt`=0, buffer=0. `rinc` is combinational and therefore 0 while `out_valid`=0 and `rempty`=1.
- `rinc` = !`rempty` & !`flush` & (`idx`!=PACK-1 | !`out_valid` | `out_ready`).
  - Never pops an empty FIFO.
  - Never pops the closing word while a completed word is still unaccepted.
- On a pop with `idx`<PACK-1: `buf[idx]`<=`rdata`, `idx`<=`idx`+1.
- On a pop with `idx`=PACK-1:
  - `out_data`<={`rdata`, `buf[PACK-2]`, …, `buf[0]`}, `out_valid`<=1, `idx`<=0.
  - If `out_valid` & `out_ready` in the same cycle, the old word is accepted and the new word loads. No bubble.
- When `out_valid` & `out_ready` and no closing pop occurs: `out_valid`<=0. `out_data` holds its value.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `flush`=1:
  - `idx`<=0 and `rinc` is forced to 0; flush wins over any pop.
  - `out_valid` and `out_data` are untouched. A completed word is still delivered.
- `pop_cnt`<=`pop_cnt`+1 on every edge with `rinc`=1, wrapping modulo 2^CNTSIZE.
- `fill` = `idx`.
- Reset asserted mid-assembly: all state clears immediately. Partial data and any pending output word are lost.

## Timing

- `rinc` is combinational from `rempty`, `flush`, `out_ready` and internal registers. The FIFO registers `rempty`, so there is no combinational loop through the FIFO.
- Pop-to-output latency: the closing word popped at edge N gives `out_valid`=1 after edge N, and the data is visible in cycle N+1.
- Peak throughput: one FIFO word per cycle, hence one packed word per PACK cycles, sustained while `out_ready`=1.
- Back-pressure: with `out_valid`=1 and `out_ready`=0, the block keeps popping until `idx`=PACK-1, then stalls. At most PACK-1 words are buffered plus one complete output word.
- FIFO going empty mid-word: `idx` holds and assembly resumes when `rempty` falls. There is no timeout.

## Test plan

- **Reset / idle:** assert `r_rstn`=0 with `rempty`=1.
  - Required: `out_valid`=0, `rinc`=0, `pop_cnt`=0, `fill`=0.
  - Release `r_rstn`: no pops while `rempty`=1.
- **Streaming:** PACK=4, FIFO preloaded with 0x01..0x08, `out_ready`=1.
  - Required: `rinc` high 8 consecutive cycles.
  - `out_data`=0x04030201, then 0x08070605, on consecutive 4-cycle boundaries.
  - `pop_cnt`=8.
- **Back-pressure:** `out_ready`=0, FIFO holds 0x10..0x17.
  - Required: first word 0x13121110 is held with `out_valid`=1. Three more pops occur, `fill`=3, then `rinc`=0.
  - Raise `out_ready` for one cycle: 0x13121110 is accepted and 0x17161514 loads on the same edge.
- **Starved FIFO:** `rempty` toggles every other cycle while feeding 0xA0..0xA3.
  - Required: `rinc` only when `rempty`=0.
  - Single output 0xA3A2A1A0 after the 4th pop.
- **Flush:** after two pops (0x55, 0x66, `fill`=2), assert `flush` for one cycle with `rempty`=0.
  - Required: no pop that cycle, `fill`=0.
  - The next 4 words 0x01..0x04 produce 0x04030201. 0x55 and 0x66 never appear.
- **Counter wrap:** CNTSIZE=4, pop 17 words.
  - Required: `pop_cnt`=1.
